// File: rtl/vote_collector.sv
// Five-voter ballot collector: debounces raw buttons, latches yes-votes during an open
// round, and closes the round on timeout or when every voter has pressed.
module vote_collector #(
   parameter int DEB_CYCLES    = 4,
   parameter int WINDOW_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [4:0] btn,
   output logic [4:0] ballot,
   output logic [2:0] vote_cnt,
   output logic       busy,
   output logic       ballot_valid
);

   localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [WW-1:0] WIN_LOAD = WW'(WINDOW_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, OPEN, DONE} state_t;

   state_t          state_reg;
   logic [WW-1:0]   win_reg;
   logic [4:0]      deb_lvl;
   logic [4:0]      deb_prev_reg;
   logic [4:0]      press;
   logic [4:0]      ballot_next;

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_deb
         logic [DW-1:0] cnt_reg;
         logic          deb_bit_reg;

         // The counter only runs while the raw input disagrees with the settled level.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               cnt_reg     <= '0;
               deb_bit_reg <= 1'b0;
            end else if (btn[gi] == deb_bit_reg) begin
               cnt_reg <= '0;
            end else if (cnt_reg == DEB_LAST) begin
               deb_bit_reg <= btn[gi];
               cnt_reg     <= '0;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end

         assign deb_lvl[gi] = deb_bit_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) deb_prev_reg <= '0;
      else        deb_prev_reg <= deb_lvl;
   end

   assign press       = deb_lvl & ~deb_prev_reg;
   assign ballot_next = ballot | press;

   function automatic logic [2:0] popcnt5(input logic [4:0] v);
      logic [2:0] s;
      s = '0;
      for (int i = 0; i < 5; i++) s = s + {2'b00, v[i]};
      return s;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         win_reg      <= '0;
         ballot       <= '0;
         vote_cnt     <= '0;
         busy         <= 1'b0;
         ballot_valid <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               ballot_valid <= 1'b0;
               busy         <= 1'b0;
               if (start) begin
                  state_reg <= OPEN;
                  ballot    <= '0;
                  vote_cnt  <= '0;
                  win_reg   <= WIN_LOAD;
                  busy      <= 1'b1;
               end
            end
            OPEN: begin
               ballot   <= ballot_next;
               vote_cnt <= popcnt5(ballot_next);
               if (win_reg != '0) win_reg <= win_reg - 1'b1;
               // A press on the timeout cycle is kept because ballot_next is used above.
               if (win_reg == '0 || ballot_next == 5'b11111) begin
                  state_reg    <= DONE;
                  busy         <= 1'b0;
                  ballot_valid <= 1'b1;
               end
            end
            DONE: begin
               state_reg    <= IDLE;
               ballot_valid <= 1'b0;
               busy         <= 1'b0;
            end
            default: begin
               state_reg    <= IDLE;
               ballot_valid <= 1'b0;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule
